// File: rtl/uart_coeff_if.sv
// Byte-stream / coefficient-memory bundle for uart_coeff_assembler.
// master drives the received bytes; slave is the assembler.
interface uart_coeff_if #(
    parameter int AW = 8,
    parameter int CW = 16
);
    logic          i_Rx_DV;
    logic [7:0]    i_Rx_Byte;
    logic          o_Wr_En;
    logic [AW-1:0] o_Wr_Addr;
    logic [CW-1:0] o_Wr_Data;
    logic          o_Busy;
    logic          o_Frame_Done;
    logic          o_Frame_Err;
    logic [1:0]    o_Err_Code;

    modport master (
        output i_Rx_DV, i_Rx_Byte,
        input  o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Busy, o_Frame_Done, o_Frame_Err, o_Err_Code
    );

    modport slave (
        input  i_Rx_DV, i_Rx_Byte,
        output o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Busy, o_Frame_Done, o_Frame_Err, o_Err_Code
    );
endinterface

// File: rtl/uart_coeff_assembler.sv
// Assembles SYNC-framed little-endian coefficient words from a UART byte stream and
// writes them to sequential memory addresses. Define UART_COEFF_CHECKSUM_EN for an XOR trailer byte.
module uart_coeff_assembler #(
    parameter int         COEFF_BYTES  = 2,
    parameter int         N_COEFFS     = 256,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CLKS = 1740,
    localparam int        CW = 8 * COEFF_BYTES,
    localparam int        AW = $clog2(N_COEFFS),
    localparam int        BW = (COEFF_BYTES > 1) ? $clog2(COEFF_BYTES) : 1,
    localparam int        TW = $clog2(TIMEOUT_CLKS + 1)
) (
    input logic         i_Clock,
    input logic         i_Rst_n,
    uart_coeff_if.slave bus
);

`ifdef UART_COEFF_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PAYLOAD = 2'd1, S_CHECK = 2'd2, S_DONE = 2'd3} state_t;
    localparam state_t S_END = S_CHECK;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PAYLOAD = 2'd1, S_DONE = 2'd3} state_t;
    localparam state_t S_END = S_DONE;
`endif

    state_t        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] byte_idx_q, byte_idx_d;
    logic [AW-1:0] coeff_idx_q, coeff_idx_d;
    logic [CW-1:0] asm_q, asm_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [CW-1:0] wr_data_q, wr_data_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
`ifdef UART_COEFF_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic          sync_seen;
    logic          last_byte;
    logic          last_coeff;
    logic [TW-1:0] cnt_inc;
    logic          timeout_hit;
    logic [CW-1:0] asm_word;

    assign rx_dv      = bus.i_Rx_DV;
    assign rx_byte    = bus.i_Rx_Byte;
    assign sync_seen  = rx_dv && (rx_byte == SYNC_BYTE);
    assign last_byte  = (byte_idx_q == BW'(COEFF_BYTES - 1));
    assign last_coeff = (coeff_idx_q == AW'(N_COEFFS - 1));
    // cnt_q counts clocks since the last byte; the error registers as it reaches TIMEOUT_CLKS-1.
    assign cnt_inc     = cnt_q + TW'(1);
    assign timeout_hit = !rx_dv && (cnt_inc == TW'(TIMEOUT_CLKS - 1));

    always_comb begin
        asm_word = asm_q;
        asm_word[{byte_idx_q, 3'b000} +: 8] = rx_byte;
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (sync_seen) state_d = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                if (rx_dv && last_byte && last_coeff) state_d = S_END;
                else if (timeout_hit)                 state_d = S_IDLE;
            end
`ifdef UART_COEFF_CHECKSUM_EN
            S_CHECK: begin
                if (rx_dv)            state_d = (rx_byte == csum_q) ? S_DONE : S_IDLE;
                else if (timeout_hit) state_d = S_IDLE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        byte_idx_d  = byte_idx_q;
        coeff_idx_d = coeff_idx_q;
        asm_d       = asm_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
`ifdef UART_COEFF_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (sync_seen) begin
                    cnt_d       = TW'(1);
                    byte_idx_d  = '0;
                    coeff_idx_d = '0;
                    asm_d       = '0;
                    err_code_d  = 2'b00;
`ifdef UART_COEFF_CHECKSUM_EN
                    csum_d      = 8'h00;
`endif
                end
            end
            S_PAYLOAD: begin
                if (rx_dv) begin
                    cnt_d = TW'(1);
                    asm_d = asm_word;
`ifdef UART_COEFF_CHECKSUM_EN
                    csum_d = csum_q ^ rx_byte;
`endif
                    if (last_byte) begin
                        byte_idx_d  = '0;
                        wr_en_d     = 1'b1;
                        wr_addr_d   = coeff_idx_q;
                        wr_data_d   = asm_word;
                        coeff_idx_d = coeff_idx_q + AW'(1);
                    end else begin
                        byte_idx_d = byte_idx_q + BW'(1);
                    end
                end else if (timeout_hit) begin
                    err_d      = 1'b1;
                    err_code_d = 2'b01;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
`ifdef UART_COEFF_CHECKSUM_EN
            S_CHECK: begin
                if (rx_dv) begin
                    cnt_d = TW'(1);
                    if (rx_byte != csum_q) begin
                        err_d      = 1'b1;
                        err_code_d = 2'b10;
                    end
                end else if (timeout_hit) begin
                    err_d      = 1'b1;
                    err_code_d = 2'b01;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
`endif
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            cnt_q       <= '0;
            byte_idx_q  <= '0;
            coeff_idx_q <= '0;
            asm_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
`ifdef UART_COEFF_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            cnt_q       <= cnt_d;
            byte_idx_q  <= byte_idx_d;
            coeff_idx_q <= coeff_idx_d;
            asm_q       <= asm_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
`ifdef UART_COEFF_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign bus.o_Busy       = (state_q != S_IDLE);
    assign bus.o_Wr_En      = wr_en_q;
    assign bus.o_Wr_Addr    = wr_addr_q;
    assign bus.o_Wr_Data    = wr_data_q;
    assign bus.o_Frame_Done = done_q;
    assign bus.o_Frame_Err  = err_q;
    assign bus.o_Err_Code   = err_code_q;

endmodule

// File: tb/tb_uart_coeff_assembler.sv
// Bench for uart_coeff_assembler: byte vectors from a table, expected writes/done/error
// events queued on a scoreboard and matched by a negedge monitor with exact cycle timing.
module tb_uart_coeff_assembler;
    localparam int AW  = 2;
    localparam int CW  = 16;
    localparam int GAP = 20;

    logic clk;
    logic rst_n;
    int   cyc;
    int   last_samp;
    int   n_chk;
    int   n_pass;

    uart_coeff_if #(.AW(AW), .CW(CW)) bus ();

    uart_coeff_assembler #(
        .COEFF_BYTES (2),
        .N_COEFFS    (4),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CLKS(200)
    ) dut (
        .i_Clock(clk),
        .i_Rst_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]    b;
        logic          wr;
        logic [AW-1:0] addr;
        logic [CW-1:0] data;
        logic          done;
        logic          busy;
    } vec_t;

    typedef struct {
        logic [2:0]    kind;   // one-hot {err, done, wr}
        int            cyc;
        logic [AW-1:0] addr;
        logic [CW-1:0] data;
        logic [1:0]    code;
    } ev_t;

    vec_t vec[$];
    ev_t  sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic vec_t mk_vec(input logic [7:0] b, input logic wr, input logic [AW-1:0] addr,
                                    input logic [CW-1:0] data, input logic done, input logic busy);
        vec_t v;
        v.b = b; v.wr = wr; v.addr = addr; v.data = data; v.done = done; v.busy = busy;
        return v;
    endfunction

    function automatic ev_t mk_ev(input logic [2:0] kind, input int c, input logic [AW-1:0] addr,
                                  input logic [CW-1:0] data, input logic [1:0] code);
        ev_t e;
        e.kind = kind; e.cyc = c; e.addr = addr; e.data = data; e.code = code;
        return e;
    endfunction

    // Monitor: every output event must match the head of the scoreboard, on the expected cycle.
    always @(negedge clk) begin
        if (rst_n && (bus.o_Wr_En || bus.o_Frame_Done || bus.o_Frame_Err)) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", {29'd0, bus.o_Frame_Err, bus.o_Frame_Done, bus.o_Wr_En}, 32'd0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("event_kind", {29'd0, bus.o_Frame_Err, bus.o_Frame_Done, bus.o_Wr_En}, {29'd0, e.kind});
                chk("event_cycle", cyc, e.cyc);
                if (e.kind == 3'b001) begin
                    chk("wr_addr", {30'd0, bus.o_Wr_Addr}, {30'd0, e.addr});
                    chk("wr_data", {16'd0, bus.o_Wr_Data}, {16'd0, e.data});
                end
                if (e.kind == 3'b100) chk("err_code_on_err", {30'd0, bus.o_Err_Code}, {30'd0, e.code});
            end
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap - 1) @(posedge clk);
        #1;
        bus.i_Rx_DV   = 1'b1;
        bus.i_Rx_Byte = b;
        @(posedge clk);
        #1;
        bus.i_Rx_DV = 1'b0;
        last_samp   = cyc;
    endtask

    task automatic drain(input string name);
        repeat (4) @(posedge clk);
        #1;
        chk(name, sb.size(), 0);
    endtask

    task automatic run_vec(input int first, input int last, input int slow_idx);
        for (int i = first; i <= last; i++) begin
            send(vec[i].b, (i == slow_idx) ? 198 : GAP);
            chk("busy_after_byte", {31'd0, bus.o_Busy}, {31'd0, vec[i].busy});
            if (vec[i].wr)   sb.push_back(mk_ev(3'b001, last_samp, vec[i].addr, vec[i].data, 2'b00));
            if (vec[i].done) sb.push_back(mk_ev(3'b010, last_samp + 1, '0, '0, 2'b00));
        end
        drain("scoreboard_drained");
    endtask

    task automatic chk_all_zero();
        chk("rst_wr_en",   {31'd0, bus.o_Wr_En},        32'd0);
        chk("rst_wr_addr", {30'd0, bus.o_Wr_Addr},      32'd0);
        chk("rst_wr_data", {16'd0, bus.o_Wr_Data},      32'd0);
        chk("rst_busy",    {31'd0, bus.o_Busy},         32'd0);
        chk("rst_done",    {31'd0, bus.o_Frame_Done},   32'd0);
        chk("rst_err",     {31'd0, bus.o_Frame_Err},    32'd0);
        chk("rst_code",    {30'd0, bus.o_Err_Code},     32'd0);
    endtask

    int nv;

    initial begin
        n_chk = 0;
        n_pass = 0;
        last_samp = 0;
        rst_n = 1'b0;
        bus.i_Rx_DV = 1'b0;
        bus.i_Rx_Byte = 8'h00;

        vec.push_back(mk_vec(8'h00, 0, 0, 16'h0000, 0, 0));
        vec.push_back(mk_vec(8'hFF, 0, 0, 16'h0000, 0, 0));
        vec.push_back(mk_vec(8'h5A, 0, 0, 16'h0000, 0, 0));
        vec.push_back(mk_vec(8'hA5, 0, 0, 16'h0000, 0, 1));
        vec.push_back(mk_vec(8'h34, 0, 0, 16'h0000, 0, 1));
        vec.push_back(mk_vec(8'h12, 1, 0, 16'h1234, 0, 1));
        vec.push_back(mk_vec(8'h78, 0, 0, 16'h0000, 0, 1));
        vec.push_back(mk_vec(8'h56, 1, 1, 16'h5678, 0, 1));
        vec.push_back(mk_vec(8'hBC, 0, 0, 16'h0000, 0, 1));
        vec.push_back(mk_vec(8'h9A, 1, 2, 16'h9ABC, 0, 1));
        vec.push_back(mk_vec(8'hF0, 0, 0, 16'h0000, 0, 1));
`ifdef UART_COEFF_CHECKSUM_EN
        vec.push_back(mk_vec(8'hDE, 1, 3, 16'hDEF0, 0, 1));
        vec.push_back(mk_vec(8'h00, 0, 0, 16'h0000, 1, 1));
`else
        vec.push_back(mk_vec(8'hDE, 1, 3, 16'hDEF0, 1, 1));
`endif
        nv = vec.size();

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Noise bytes then a full frame
        run_vec(0, nv - 1, -1);
        chk("code_after_good_frame", {30'd0, bus.o_Err_Code}, 32'd0);

        // SYNC plus one byte, then silence: timeout error
        send(8'hA5, GAP);
        send(8'h01, GAP);
        sb.push_back(mk_ev(3'b100, last_samp + 198, '0, '0, 2'b01));
        repeat (210) @(posedge clk);
        #1;
        chk("timeout_drained", sb.size(), 0);
        chk("timeout_code", {30'd0, bus.o_Err_Code}, 32'd1);
        chk("timeout_busy", {31'd0, bus.o_Busy}, 32'd0);

        // Byte arriving on the terminal-count cycle is accepted
        run_vec(3, nv - 1, 5);
        chk("terminal_code", {30'd0, bus.o_Err_Code}, 32'd0);

`ifdef UART_COEFF_CHECKSUM_EN
        // Bad checksum after a complete payload
        run_vec(3, nv - 2, -1);
        send(8'h01, GAP);
        sb.push_back(mk_ev(3'b100, last_samp, '0, '0, 2'b10));
        drain("csum_err_drained");
        chk("csum_code", {30'd0, bus.o_Err_Code}, 32'd2);
        chk("csum_busy", {31'd0, bus.o_Busy}, 32'd0);
`endif

        // Reset in the middle of a frame
        run_vec(3, 6, -1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_vec(3, nv - 1, -1);

        repeat (5) @(posedge clk);
        #1;
        chk("final_drained", sb.size(), 0);
        chk("final_busy", {31'd0, bus.o_Busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
